// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - fetch stall / hazard controller with MDU busy timer and stall counter
module fetch_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_dst,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_dst,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_isdiv,
    output logic        PC_en,
    output logic        D_en,
    output logic        E_flush,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic [CNT_W-1:0] cnt;
    logic             rs_e;
    logic             rs_m;
    logic             rt_e;
    logic             rt_m;
    logic             md_hz;
    logic             stall;

    // A consumer stalls only when its operand is needed before the producer can forward it.
    always_comb begin
        rs_e    = (D_rs_addr != 5'd0) && (D_rs_addr == E_dst) && (D_tuse_rs < E_tnew);
        rs_m    = (D_rs_addr != 5'd0) && (D_rs_addr == M_dst) && (D_tuse_rs < M_tnew);
        rt_e    = (D_rt_addr != 5'd0) && (D_rt_addr == E_dst) && (D_tuse_rt < E_tnew);
        rt_m    = (D_rt_addr != 5'd0) && (D_rt_addr == M_dst) && (D_tuse_rt < M_tnew);
        md_busy = E_md_start || (cnt != '0);
        md_hz   = D_is_md && md_busy;
        stall   = rs_e || rs_m || rt_e || rt_m || md_hz;
        PC_en   = !stall;
        D_en    = !stall;
        E_flush = stall;
    end

    // A start arriving while the timer runs is ignored; the count is never reloaded or extended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (E_md_start && (cnt == '0)) begin
            cnt <= E_md_isdiv ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb/tb_fetch_stall_ctrl.sv - table-driven and sequence checks for fetch_stall_ctrl
module tb_fetch_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_dst;
    logic [1:0]  E_tnew;
    logic [4:0]  M_dst;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_isdiv;
    logic        PC_en;
    logic        D_en;
    logic        E_flush;
    logic        md_busy;
    logic [31:0] stall_cnt;

    int n_cmp;
    int n_bad;
    logic [31:0] exp_cnt;

    fetch_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs_addr  (D_rs_addr),
        .D_rt_addr  (D_rt_addr),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_dst      (E_dst),
        .E_tnew     (E_tnew),
        .M_dst      (M_dst),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .E_md_isdiv (E_md_isdiv),
        .PC_en      (PC_en),
        .D_en       (D_en),
        .E_flush    (E_flush),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       is_md;
        logic [4:0] e_dst;
        logic [1:0] e_tnew;
        logic [4:0] m_dst;
        logic [1:0] m_tnew;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        D_rs_addr  = 5'd0;
        D_rt_addr  = 5'd0;
        D_tuse_rs  = 2'd3;
        D_tuse_rt  = 2'd3;
        D_is_md    = 1'b0;
        E_dst      = 5'd0;
        E_tnew     = 2'd0;
        M_dst      = 5'd0;
        M_tnew     = 2'd0;
        E_md_start = 1'b0;
        E_md_isdiv = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds D_is_md and pulses one start; busy must last the start cycle plus lat further cycles.
    task automatic md_seq(input logic isdiv, input int lat, input string tag);
        idle();
        D_is_md    = 1'b1;
        E_md_start = 1'b1;
        E_md_isdiv = isdiv;
        for (int i = 0; i <= lat + 1; i++) begin
            #1;
            check({tag, "_busy"}, {31'd0, md_busy}, {31'd0, (i <= lat)});
            check({tag, "_pc_en"}, {31'd0, PC_en}, {31'd0, (i > lat)});
            if (i <= lat) exp_cnt = exp_cnt + 32'd1;
            step();
            E_md_start = 1'b0;
        end
        check({tag, "_stall_cnt"}, stall_cnt, exp_cnt);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 32'd0;

        //          rs  rt  trs trt md  edst etn mdst mtn stall
        vecs[0] = '{5'd8,  5'd0, 2'd1, 2'd3, 1'b0, 5'd8,  2'd2, 5'd0, 2'd0, 1'b1};
        vecs[1] = '{5'd8,  5'd0, 2'd2, 2'd3, 1'b0, 5'd8,  2'd2, 5'd0, 2'd0, 1'b0};
        vecs[2] = '{5'd0,  5'd0, 2'd0, 2'd0, 1'b0, 5'd0,  2'd2, 5'd0, 2'd0, 1'b0};
        vecs[3] = '{5'd0,  5'd9, 2'd3, 2'd0, 1'b0, 5'd0,  2'd0, 5'd9, 2'd1, 1'b1};
        vecs[4] = '{5'd0,  5'd9, 2'd3, 2'd1, 1'b0, 5'd0,  2'd0, 5'd9, 2'd1, 1'b0};
        vecs[5] = '{5'd5,  5'd0, 2'd3, 2'd3, 1'b0, 5'd5,  2'd2, 5'd0, 2'd0, 1'b0};
        vecs[6] = '{5'd0,  5'd12, 2'd3, 2'd0, 1'b0, 5'd12, 2'd1, 5'd0, 2'd0, 1'b1};
        vecs[7] = '{5'd3,  5'd0, 2'd0, 2'd3, 1'b0, 5'd4,  2'd2, 5'd0, 2'd0, 1'b0};
        vecs[8] = '{5'd7,  5'd0, 2'd1, 2'd3, 1'b0, 5'd0,  2'd0, 5'd7, 2'd2, 1'b1};
        vecs[9] = '{5'd0,  5'd0, 2'd3, 2'd3, 1'b1, 5'd0,  2'd0, 5'd0, 2'd0, 1'b0};

        idle();
        reset = 1'b1;
        #12;
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        check("rst_pc_en", {31'd0, PC_en}, 32'd1);
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            D_rs_addr = vecs[i].rs;
            D_rt_addr = vecs[i].rt;
            D_tuse_rs = vecs[i].tuse_rs;
            D_tuse_rt = vecs[i].tuse_rt;
            D_is_md   = vecs[i].is_md;
            E_dst     = vecs[i].e_dst;
            E_tnew    = vecs[i].e_tnew;
            M_dst     = vecs[i].m_dst;
            M_tnew    = vecs[i].m_tnew;
            #1;
            check($sformatf("vec%0d_pc_en", i), {31'd0, PC_en}, {31'd0, !vecs[i].exp_stall});
            check($sformatf("vec%0d_d_en", i), {31'd0, D_en}, {31'd0, !vecs[i].exp_stall});
            check($sformatf("vec%0d_e_flush", i), {31'd0, E_flush}, {31'd0, vecs[i].exp_stall});
            if (vecs[i].exp_stall) exp_cnt = exp_cnt + 32'd1;
            step();
            check($sformatf("vec%0d_stall_cnt", i), stall_cnt, exp_cnt);
        end

        md_seq(1'b0, 5, "mult");
        md_seq(1'b1, 10, "div");

        // Reset three cycles into a div must clear everything between clock edges.
        idle();
        D_is_md    = 1'b1;
        E_md_start = 1'b1;
        E_md_isdiv = 1'b1;
        step();
        E_md_start = 1'b0;
        step();
        step();
        #1;
        check("middiv_busy_before", {31'd0, md_busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("middiv_busy", {31'd0, md_busy}, 32'd0);
        check("middiv_stall_cnt", stall_cnt, 32'd0);
        check("middiv_pc_en", {31'd0, PC_en}, 32'd1);
        exp_cnt = 32'd0;
        step();
        reset = 1'b0;
        step();
        check("postrst_busy", {31'd0, md_busy}, 32'd0);
        check("postrst_stall_cnt", stall_cnt, 32'd0);

        // A div start two cycles into a mult must not reload or extend the timer.
        idle();
        E_md_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rebusy%0d", i), {31'd0, md_busy}, {31'd0, (i < 6)});
            step();
            E_md_start = (i == 1);
            E_md_isdiv = (i == 1);
        end
        check("rebusy_stall_cnt", stall_cnt, exp_cnt);

        idle();
        M_dst     = 5'd9;
        M_tnew    = 2'd1;
        D_rt_addr = 5'd9;
        D_tuse_rt = 2'd0;
        #1;
        check("m_hz_e_flush", {31'd0, E_flush}, 32'd1);
        check("m_hz_pc_en", {31'd0, PC_en}, 32'd0);
        exp_cnt = exp_cnt + 32'd1;
        step();
        check("m_hz_stall_cnt", stall_cnt, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
- Hazard and stall controller for the 5-stage pipelined CPU.
- Decides each cycle whether the fetch stage may advance:
  - drives the PC enable into the IFU;
  - drives the IF/ID register enable;
  - inserts a bubble into ID/EX.
- Owns the multiply/divide busy timer. Detects register-file RAW hazards that forwarding cannot cover (Tuse/Tnew rule) and HI/LO hazards.
- Keeps a stall-cycle performance counter.

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu start
- DIV_LAT, 10, busy cycles after a div/divu start
- CNT_W, 4, width of the internal busy down-counter; must hold DIV_LAT

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- D_rs_addr  in  5  rs index of the instruction in D
- D_rt_addr  in  5  rt index of the instruction in D
- D_tuse_rs  in  2  cycles until D instruction needs rs (3 = not used)
- D_tuse_rt  in  2  cycles until D instruction needs rt (3 = not used)
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_dst  in  5  destination register of the instruction in E (0 = none)
- E_tnew  in  2  cycles until the E result is available
- M_dst  in  5  destination register of the instruction in M
- M_tnew  in  2  cycles until the M result is available
- E_md_start  in  1  a mult/div is in E this cycle
- E_md_isdiv  in  1  1 = div/divu, 0 = mult/multu (valid with E_md_start)
- PC_en  out  1  IFU PC write enable
- D_en  out  1  IF/ID register enable
- E_flush  out  1  clear ID/EX (insert nop)
- md_busy  out  1  MDU busy, including the start cycle
- stall_cnt  out  32  total stalled cycles since reset

Behaviour:
- Hazard terms (all combinational):
  - rs_E = (D_rs_addr != 0) & (D_rs_addr == E_dst) & (D_tuse_rs < E_tnew)
  - rs_M = (D_rs_addr != 0) & (D_rs_addr == M_dst) & (D_tuse_rs < M_tnew)
  - rt_E and rt_M are the same with D_rt_addr and D_tuse_rt.
  - md_hz = D_is_md & md_busy
  - stall = rs_E | rs_M | rt_E | rt_M | md_hz
- Outputs from stall:
  - PC_en = ~stall, D_en = ~stall, E_flush = stall.
  - No register between the hazard terms and these outputs, so a stall takes effect in the same cycle.
- Busy timer:
  - On a clk edge with E_md_start=1 and cnt==0, cnt loads DIV_LAT if E_md_isdiv, else MULT_LAT.
  - Otherwise, if cnt != 0, cnt decrements by 1.
  - md_busy = E_md_start | (cnt != 0).
  - Result: a mult stalls a dependent md instruction in D during its start cycle plus 5 further cycles; a div, during its start cycle plus 10.
- Start while busy: E_md_start with cnt != 0 is ignored; the count continues, with no reload and no extension. This cannot happen in legal flow because md_hz blocks the start; the verification engineer must still check that it is ignored.
- stall_cnt:
  - Increments by 1 on every clk edge where stall=1.
  - Wraps from 0xFFFFFFFF to 0.
- Reset (asynchronous):
  - cnt=0, stall_cnt=0 immediately, without waiting for a clk edge.
  - Resulting outputs: md_busy=E_md_start, PC_en/D_en/E_flush follow the combinational equations.
  - Reset during an active mult/div aborts the busy period at once.
- Register 0 never creates a hazard.
- Tuse=3 never stalls, because Tnew is at most 2.

Test Plan:
- RAW on lw→add: E_dst=8, E_tnew=2, D_rs_addr=8, D_tuse_rs=1 → stall=1, PC_en=0, D_en=0, E_flush=1. Same case with D_tuse_rs=2 → stall=0.
- $0 exclusion: E_dst=0, E_tnew=2, D_rs_addr=0, D_tuse_rt=0 → PC_en=1, stall_cnt unchanged.
- mult then mflo:
  - Pulse E_md_start=1 (E_md_isdiv=0) for one cycle with D_is_md=1 held.
  - Required: md_busy=1 in the start cycle and the next 5 cycles, 0 on the 7th; stall_cnt=6.
- div then mfhi: as above with E_md_isdiv=1 → md_busy high for 11 cycles total; stall_cnt=11.
- Reset mid-div:
  - Assert reset 3 cycles after a div start, with no clk edge needed.
  - Required: md_busy=0, stall_cnt=0, PC_en=1 with D_is_md=1.
- Start during busy + M hazard:
  - Second E_md_start 2 cycles into a mult → busy ends at the original time.
  - M_dst=9, M_tnew=1, D_rt_addr=9, D_tuse_rt=0 → stall=1.
